// File: rtl/isa_pkg.sv
// ============================================================================
// Module  : isa_pkg
// Brief   : Instruction formats, field slices and loader FSM states.
// Revision: 1.0
// ============================================================================
`default_nettype none

package isa_pkg;

  localparam int WORD_W    = 16;

  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RS_MSB    = 11;
  localparam int RS_LSB    = 9;
  localparam int RT_MSB    = 8;
  localparam int RT_LSB    = 6;
  localparam int RD_MSB    = 5;
  localparam int RD_LSB    = 3;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;
  localparam int JADDR_MSB = 11;
  localparam int JADDR_LSB = 0;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_BAD = 2'd3
  } fmt_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    DRAIN = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/instr_pack.sv
// ============================================================================
// Module  : instr_pack
// Brief   : Combinational packer from instruction fields to a 16-bit word.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_pack
  import isa_pkg::*;
(
  input  fmt_e              fmt_i,
  input  logic [3:0]        op_i,
  input  logic [2:0]        rs_i,
  input  logic [2:0]        rt_i,
  input  logic [2:0]        rd_i,
  input  logic [5:0]        imm_i,
  input  logic [11:0]       jaddr_i,
  output logic [WORD_W-1:0] word_o,
  output logic              illegal_o
);

  // Illegal format yields an all-zero word so imem never holds a half-built encoding.
  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (fmt_i)
      FMT_R: begin
        word_o[OP_MSB:OP_LSB] = op_i;
        word_o[RS_MSB:RS_LSB] = rs_i;
        word_o[RT_MSB:RT_LSB] = rt_i;
        word_o[RD_MSB:RD_LSB] = rd_i;
      end
      FMT_I: begin
        word_o[OP_MSB:OP_LSB]   = op_i;
        word_o[RS_MSB:RS_LSB]   = rs_i;
        word_o[RT_MSB:RT_LSB]   = rt_i;
        word_o[IMM_MSB:IMM_LSB] = imm_i;
      end
      FMT_J: begin
        word_o[OP_MSB:OP_LSB]       = op_i;
        word_o[JADDR_MSB:JADDR_LSB] = jaddr_i;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/instr_encoder_loader.sv
// ============================================================================
// Module  : instr_encoder_loader
// Brief   : Streams encoded instruction words into imem at boot, holding the CPU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_encoder_loader
  import isa_pkg::*;
#(
  parameter int N      = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [1:0]        in_fmt,
  input  logic [3:0]        in_op,
  input  logic [2:0]        in_rs,
  input  logic [2:0]        in_rt,
  input  logic [2:0]        in_rd,
  input  logic [5:0]        in_imm,
  input  logic [11:0]       in_jaddr,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [N-1:0]      imem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q;
  logic [ADDR_W:0]     count_q;
  logic                err_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [N-1:0]        wd_q;

  logic                accept;
  logic                sess_start;
  logic                at_end;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_illegal;

  instr_pack u_pack (
    .fmt_i     (fmt_e'(in_fmt)),
    .op_i      (in_op),
    .rs_i      (in_rs),
    .rt_i      (in_rt),
    .rd_i      (in_rd),
    .imm_i     (in_imm),
    .jaddr_i   (in_jaddr),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  assign accept     = in_valid & in_ready;
  assign sess_start = start & ((state_q == IDLE) | (state_q == DONE) | (state_q == ERR));
  assign at_end     = (ptr_q == LAST_PTR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // DRAIN covers the final write cycle; a session with any error ends in ERR, never DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD:      if (accept && (in_last || at_end)) state_d = DRAIN;
      DRAIN:     state_d = err_q ? ERR : DONE;
      DONE, ERR: if (start) state_d = LOAD;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q == LOAD);
    done     = (state_q == DONE);
    cpu_hold = (state_q != DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q   <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      we_q <= accept;
      if (sess_start) begin
        ptr_q   <= '0;
        count_q <= '0;
        err_q   <= 1'b0;
      end else if (accept) begin
        addr_q  <= ptr_q;
        wd_q    <= N'(enc_word);
        ptr_q   <= ptr_q + ADDR_W'(1);
        count_q <= count_q + (ADDR_W + 1)'(1);
        if (enc_illegal || (at_end && !in_last)) err_q <= 1'b1;
      end
    end
  end

  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wd   = wd_q;
  assign err       = err_q;
  assign count     = count_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder_loader.sv
// ============================================================================
// Module  : tb_instr_encoder_loader
// Brief   : Directed table-driven bench for instr_encoder_loader (two depths).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_encoder_loader;

  typedef struct {
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [5:0]  imm;
    logic [11:0] jaddr;
    logic        last;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] wd;
    int          c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [1:0]  in_fmt = '0;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_imm = '0;
  logic [11:0] in_jaddr = '0;
  logic        sel4 = 1'b0;

  logic        a_valid, b_valid;
  logic        a_rdy, a_we, a_hold, a_done, a_err;
  logic [7:0]  a_addr;
  logic [15:0] a_wd;
  logic [8:0]  a_cnt;
  logic        b_rdy, b_we, b_hold, b_done, b_err;
  logic [7:0]  b_addr;
  logic [15:0] b_wd;
  logic [8:0]  b_cnt;

  logic        rdy, we, hold, dn, er;
  logic [7:0]  addr;
  logic [15:0] wd;
  logic [8:0]  cnt;

  assign a_valid = in_valid & ~sel4;
  assign b_valid = in_valid & sel4;
  assign rdy  = sel4 ? b_rdy  : a_rdy;
  assign we   = sel4 ? b_we   : a_we;
  assign hold = sel4 ? b_hold : a_hold;
  assign dn   = sel4 ? b_done : a_done;
  assign er   = sel4 ? b_err  : a_err;
  assign addr = sel4 ? b_addr : a_addr;
  assign wd   = sel4 ? b_wd   : a_wd;
  assign cnt  = sel4 ? b_cnt  : a_cnt;

  instr_encoder_loader u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(a_valid), .in_ready(a_rdy),
    .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_jaddr(in_jaddr), .imem_we(a_we),
    .imem_addr(a_addr), .imem_wd(a_wd), .cpu_hold(a_hold), .done(a_done),
    .err(a_err), .count(a_cnt)
  );

  instr_encoder_loader #(.DEPTH(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .in_valid(b_valid), .in_ready(b_rdy),
    .in_last(in_last), .in_fmt(in_fmt), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt),
    .in_rd(in_rd), .in_imm(in_imm), .in_jaddr(in_jaddr), .imem_we(b_we),
    .imem_addr(b_addr), .imem_wd(b_wd), .cpu_hold(b_hold), .done(b_done),
    .err(b_err), .count(b_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  vec_t        tbl [0:6];
  wr_t         wq[$];
  int          accq[$];
  logic [15:0] eq[$];
  int          total = 0;
  int          bad = 0;

  always @(negedge clk) begin
    if (we === 1'b1) wq.push_back('{addr, wd, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    in_fmt = v.fmt; in_op = v.op; in_rs = v.rs; in_rt = v.rt;
    in_rd = v.rd; in_imm = v.imm; in_jaddr = v.jaddr;
  endtask

  task automatic clear_q();
    wq.delete(); accq.delete(); eq.delete();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; start = 1'b0; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_q();
  endtask

  task automatic kick_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input int k, input bit nolast);
    int t;
    apply(tbl[k]);
    in_last  = nolast ? 1'b0 : tbl[k].last;
    in_valid = 1'b1;
    t = 0;
    while (rdy !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (rdy !== 1'b1) begin
      chk($sformatf("send_timeout_vec%0d", k), 32'(rdy), 32'd1);
      in_valid = 1'b0;
      return;
    end
    accq.push_back(cyc + 1);
    eq.push_back(tbl[k].exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_fmt = 2'($urandom_range(0, 3)); in_op = 4'($urandom);
      in_jaddr = 12'($urandom); in_last = 1'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic check_session(input string nm);
    int n;
    chk({nm, "_nwrites"}, 32'(wq.size()), 32'(eq.size()));
    n = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", nm, i), 32'(wq[i].addr), 32'(i));
      chk($sformatf("%s_word%0d", nm, i), 32'(wq[i].wd), 32'(eq[i]));
      chk($sformatf("%s_cyc%0d", nm, i), 32'(wq[i].c), 32'(accq[i]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    //         fmt    op    rs    rt    rd    imm     jaddr     last  expected
    tbl[0] = '{2'd0, 4'h1, 3'd1, 3'd2, 3'd3, 6'h2A, 12'h555, 1'b0, 16'h1298};
    tbl[1] = '{2'd0, 4'h2, 3'd3, 3'd4, 3'd5, 6'h15, 12'hAAA, 1'b0, 16'h2728};
    tbl[2] = '{2'd0, 4'h3, 3'd7, 3'd0, 3'd1, 6'h3F, 12'hFFF, 1'b1, 16'h3E08};
    tbl[3] = '{2'd1, 4'h4, 3'd2, 3'd5, 3'd7, 6'h3F, 12'h123, 1'b0, 16'h457F};
    tbl[4] = '{2'd2, 4'h8, 3'd7, 3'd7, 3'd7, 6'h3F, 12'hABC, 1'b1, 16'h8ABC};
    tbl[5] = '{2'd3, 4'hF, 3'd7, 3'd7, 3'd7, 6'h3F, 12'hFFF, 1'b0, 16'h0000};
    tbl[6] = '{2'd1, 4'hA, 3'd0, 3'd7, 3'd2, 6'h01, 12'h000, 1'b1, 16'hA1C1};

    // reset values while reset_n is low
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(a_rdy), 32'd0);
    chk("rst_we", 32'(a_we), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wd", 32'(a_wd), 32'd0);
    chk("rst_hold", 32'(a_hold), 32'd1);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_err", 32'(a_err), 32'd0);
    chk("rst_count", 32'(a_cnt), 32'd0);

    // 1: three R-type words back to back
    do_reset();
    kick_start();
    send(0, 1'b0); send(1, 1'b0); send(2, 1'b0);
    repeat (2) @(negedge clk);
    check_session("t1");
    if (wq.size() >= 3) chk("t1_span", 32'(wq[2].c - wq[0].c), 32'd2);
    chk("t1_done", 32'(dn), 32'd1);
    chk("t1_hold", 32'(hold), 32'd0);
    chk("t1_count", 32'(cnt), 32'd3);
    chk("t1_err", 32'(er), 32'd0);
    chk("t1_ready", 32'(rdy), 32'd0);

    // 2: restart from DONE, I-type then J-type
    clear_q();
    kick_start();
    chk("t2_hold_back", 32'(hold), 32'd1);
    chk("t2_done_clr", 32'(dn), 32'd0);
    chk("t2_count_clr", 32'(cnt), 32'd0);
    send(3, 1'b0); send(4, 1'b0);
    repeat (2) @(negedge clk);
    check_session("t2");
    chk("t2_done", 32'(dn), 32'd1);
    chk("t2_count", 32'(cnt), 32'd2);

    // 3: valid outside LOAD ignored, then gapped stream
    do_reset();
    apply(tbl[0]); in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t3_idle_nowrite", 32'(wq.size()), 32'd0);
    kick_start();
    send(0, 1'b0); gap(2); send(3, 1'b0); gap(1); send(1, 1'b0); gap(3); send(6, 1'b0);
    repeat (2) @(negedge clk);
    check_session("t3");
    chk("t3_done", 32'(dn), 32'd1);
    chk("t3_count", 32'(cnt), 32'd4);

    // 4: DEPTH=4 overflow
    sel4 = 1'b1;
    do_reset();
    kick_start();
    send(0, 1'b1); send(1, 1'b1); send(3, 1'b1); send(0, 1'b1);
    apply(tbl[1]); in_last = 1'b0; in_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rdy === 1'b1) seen++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("t4_fifth_accepted", 32'(seen), 32'd0);
    check_session("t4");
    chk("t4_err", 32'(er), 32'd1);
    chk("t4_hold", 32'(hold), 32'd1);
    chk("t4_ready", 32'(rdy), 32'd0);
    chk("t4_done", 32'(dn), 32'd0);
    chk("t4_count", 32'(cnt), 32'd4);
    sel4 = 1'b0;

    // 5: illegal format mid-stream
    do_reset();
    kick_start();
    send(0, 1'b0); send(5, 1'b0);
    chk("t5_err_set", 32'(er), 32'd1);
    send(1, 1'b0);
    chk("t5_err_sticky", 32'(er), 32'd1);
    send(2, 1'b0);
    repeat (2) @(negedge clk);
    check_session("t5");
    chk("t5_err_end", 32'(er), 32'd1);
    chk("t5_done", 32'(dn), 32'd0);
    chk("t5_hold", 32'(hold), 32'd1);

    // 6: asynchronous reset mid-load, then reload from address 0
    do_reset();
    kick_start();
    send(0, 1'b0); send(1, 1'b0);
    chk("t6_pre_we", 32'(we), 32'd1);
    chk("t6_pre_addr", 32'(addr), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_we", 32'(we), 32'd0);
    chk("t6_addr", 32'(addr), 32'd0);
    chk("t6_wd", 32'(wd), 32'd0);
    chk("t6_count", 32'(cnt), 32'd0);
    chk("t6_ready", 32'(rdy), 32'd0);
    chk("t6_hold", 32'(hold), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    clear_q();
    kick_start();
    send(3, 1'b0); send(4, 1'b0);
    repeat (2) @(negedge clk);
    check_session("t6");
    chk("t6_done", 32'(dn), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
